// File: rtl/jk_bank_ctrl.sv
// Command sequencer that drives per-bit J/K into an external JK flip-flop bank.
// Optional JKC_WRAP_STOP_EN: UP/DOWN runs halt at terminal count and report sat.

module jk_lane (
  input  logic [2:0] op,
  input  logic       en,
  input  logic       d,
  input  logic       tu,
  input  logic       td,
  output logic       j,
  output logic       k
);
  always_comb begin
    j = 1'b0;
    k = 1'b0;
    if (en) begin
      case (op)
        3'd1: k = 1'b1;
        3'd2: begin j = d;  k = ~d; end
        3'd3: begin j = tu; k = tu; end
        3'd4: begin j = td; k = td; end
        3'd5: begin j = d;  k = d;  end
        default: ;
      endcase
    end
  end
endmodule

module jk_bank_ctrl #(
  parameter int W  = 4,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [W-1:0]  cmd_data,
  input  logic [LW-1:0] cmd_len,
  input  logic [W-1:0]  q_in,
  output logic [W-1:0]  j_out,
  output logic [W-1:0]  k_out,
  output logic          busy,
  output logic          done,
  output logic          tc
`ifdef JKC_WRAP_STOP_EN
  , output logic        sat
`endif
);
  localparam logic [LW-1:0] ONE = 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] data;
  } cmd_t;

  state_t        st, st_nx;
  cmd_t          cmd_q;
  logic [LW-1:0] rem;
  logic [W-1:0]  up_c, dn_c;
  logic          run, en, stop;

  assign run = (st == RUN);

  // t[i] of the up/down counter: carry/borrow ripple over lower Q bits
  for (genvar i = 0; i < W; i++) begin : g_lane
    if (i == 0) begin : g_lsb
      assign up_c[i] = 1'b1;
      assign dn_c[i] = 1'b1;
    end else begin : g_msb
      assign up_c[i] = up_c[i-1] & q_in[i-1];
      assign dn_c[i] = dn_c[i-1] & ~q_in[i-1];
    end
    jk_lane u_lane (
      .op (cmd_q.op),
      .en (en),
      .d  (cmd_q.data[i]),
      .tu (up_c[i]),
      .td (dn_c[i]),
      .j  (j_out[i]),
      .k  (k_out[i])
    );
  end

  assign tc = run && (((cmd_q.op == 3'd3) && (&q_in)) ||
                      ((cmd_q.op == 3'd4) && !(|q_in)));

`ifdef JKC_WRAP_STOP_EN
  logic sat_q;
  assign stop = tc;
  assign sat  = sat_q;
`else
  assign stop = 1'b0;
`endif
  assign en = run && !stop;

  assign cmd_ready = (st == IDLE) && rst;
  assign busy      = (st != IDLE) && rst;
  assign done      = (st == DONE) && rst;

  always_comb begin
    st_nx = st;
    case (st)
      IDLE:    if (cmd_valid && cmd_ready) st_nx = RUN;
      RUN:     if (rem <= ONE || stop) st_nx = DONE;
      DONE:    st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st    <= IDLE;
      cmd_q <= '0;
      rem   <= '0;
`ifdef JKC_WRAP_STOP_EN
      sat_q <= 1'b0;
`endif
    end else begin
      st <= st_nx;
      if (st == IDLE && cmd_valid) begin
        cmd_q <= '{op: cmd_op, data: cmd_data};
        rem   <= (cmd_len == '0) ? ONE : cmd_len;
      end else if (run) begin
        rem <= rem - ONE;
      end
`ifdef JKC_WRAP_STOP_EN
      sat_q <= run && stop;
`endif
    end
  end
endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Directed bench for jk_bank_ctrl with a behavioural JK bank closing the loop.
// Expectations switch on JKC_WRAP_STOP_EN.

module tb_jk_bank_ctrl;
  localparam int W  = 4;
  localparam int LW = 8;

  logic          clk, rst;
  logic          cmd_valid, cmd_ready;
  logic [2:0]    cmd_op;
  logic [W-1:0]  cmd_data;
  logic [LW-1:0] cmd_len;
  logic [W-1:0]  q, j_out, k_out;
  logic          busy, done, tc;
  logic          bank_ld;
  logic [W-1:0]  bank_val;
`ifdef JKC_WRAP_STOP_EN
  logic          sat;
`endif

  int total, bad;
  int busy_cnt, done_cnt, done_idx, tc_cnt, sat_seen;
  logic [W-1:0] q_log [0:299];
  logic [W-1:0] j_log [0:299];
  logic [W-1:0] k_log [0:299];
  logic         tc_log[0:299];

  jk_bank_ctrl #(.W(W), .LW(LW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_len(cmd_len),
    .q_in(q), .j_out(j_out), .k_out(k_out),
    .busy(busy), .done(done), .tc(tc)
`ifdef JKC_WRAP_STOP_EN
    , .sat(sat)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external JK bank
  always @(posedge clk)
    if (bank_ld) q <= bank_val;
    else         q <= (j_out & ~q) | (~k_out & q);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [W-1:0] v);
    bank_ld = 1'b1; bank_val = v;
    @(negedge clk);
    bank_ld = 1'b0;
  endtask

  // issue at a negedge, then log ncyc negedge samples starting with the first RUN cycle
  task automatic do_cmd(input logic [2:0] op, input logic [W-1:0] d,
                        input logic [LW-1:0] len, input int ncyc, input bit hold);
    cmd_op = op; cmd_data = d; cmd_len = len; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (hold) begin cmd_op = 3'd2; cmd_data = '1; cmd_len = 8'd1; end
    else cmd_valid = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_idx = -1; tc_cnt = 0; sat_seen = 0;
    for (int i = 0; i < ncyc; i++) begin
      q_log[i] = q; j_log[i] = j_out; k_log[i] = k_out; tc_log[i] = tc;
      busy_cnt += int'(busy);
      tc_cnt   += int'(tc);
      if (done) begin
        done_cnt++;
        if (done_idx < 0) done_idx = i;
        cmd_valid = 1'b0;
`ifdef JKC_WRAP_STOP_EN
        sat_seen = int'(sat);
`endif
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_len = '0;
    bank_ld = 1'b1; bank_val = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_jk",    {j_out, k_out}, 0);
    chk("rst_tc",    tc, 0);
    rst = 1'b1; bank_ld = 1'b0;
    #1 chk("idle_ready", cmd_ready, 1);
    @(negedge clk);

    // LOAD 1010
    do_cmd(3'd2, 4'b1010, 8'd1, 4, 0);
    chk("load_j", j_log[0], 4'b1010);
    chk("load_k", k_log[0], 4'b0101);
    chk("load_done_idx", done_idx, 1);
    chk("load_done_cnt", done_cnt, 1);
    chk("load_busy", busy_cnt, 2);
    chk("load_q", q, 4'b1010);
    chk("load_ready", cmd_ready, 1);

    // UP x5 from 0
    preload(4'h0);
    do_cmd(3'd3, 4'h0, 8'd5, 8, 0);
    chk("up_q2", q_log[2], 4'h2);
    chk("up_q4", q_log[4], 4'h4);
    chk("up_busy", busy_cnt, 6);
    chk("up_done_cnt", done_cnt, 1);
    chk("up_done_idx", done_idx, 5);
    chk("up_tc", tc_cnt, 0);
    chk("up_q", q, 4'h5);

    // UP across wrap from E
    preload(4'hE);
    do_cmd(3'd3, 4'h0, 8'd3, 6, 0);
    chk("upw_tc0", tc_log[0], 0);
    chk("upw_tc1", tc_log[1], 1);
    chk("upw_tc_cnt", tc_cnt, 1);
`ifdef JKC_WRAP_STOP_EN
    chk("upw_jk_stop", {j_log[1], k_log[1]}, 0);
    chk("upw_done_idx", done_idx, 2);
    chk("upw_sat", sat_seen, 1);
    chk("upw_q", q, 4'hF);
`else
    chk("upw_q2", q_log[2], 4'h0);
    chk("upw_done_idx", done_idx, 3);
    chk("upw_q", q, 4'h1);
`endif

    // DOWN from 0
    preload(4'h0);
    do_cmd(3'd4, 4'h0, 8'd2, 5, 0);
    chk("dn_tc0", tc_log[0], 1);
    chk("dn_tc_cnt", tc_cnt, 1);
`ifdef JKC_WRAP_STOP_EN
    chk("dn_jk_stop", {j_log[0], k_log[0]}, 0);
    chk("dn_done_idx", done_idx, 1);
    chk("dn_sat", sat_seen, 1);
    chk("dn_q", q, 4'h0);
`else
    chk("dn_j0", j_log[0], 4'hF);
    chk("dn_q1", q_log[1], 4'hF);
    chk("dn_done_idx", done_idx, 2);
    chk("dn_q", q, 4'hE);
`endif

    // TOGGLE 0110 twice
    preload(4'h0);
    do_cmd(3'd5, 4'b0110, 8'd2, 5, 0);
    chk("tog_q1", q_log[1], 4'h6);
    chk("tog_done_idx", done_idx, 2);
    chk("tog_q", q, 4'h0);
`ifdef JKC_WRAP_STOP_EN
    chk("tog_sat", sat_seen, 0);
`endif

    // CLEAR with len 0
    preload(4'hA);
    do_cmd(3'd1, 4'h0, 8'd0, 4, 0);
    chk("clr_jk", {j_log[0], k_log[0]}, 8'h0F);
    chk("clr_busy", busy_cnt, 2);
    chk("clr_done_idx", done_idx, 1);
    chk("clr_q", q, 4'h0);

    // reserved op
    preload(4'hA);
    do_cmd(3'd7, 4'hF, 8'd1, 4, 0);
    chk("rsv_jk", {j_log[0], k_log[0]}, 0);
    chk("rsv_q", q, 4'hA);

    // command held valid and altered while busy
    preload(4'h0);
    do_cmd(3'd3, 4'h0, 8'd3, 7, 1);
    chk("hold_j0", j_log[0], 4'h1);
    chk("hold_done_cnt", done_cnt, 1);
    chk("hold_q", q, 4'h3);

    // maximum length
    preload(4'h0);
    do_cmd(3'd3, 4'h0, 8'd255, 260, 0);
    chk("long_q", q, 4'hF);
    chk("long_done_cnt", done_cnt, 1);
`ifdef JKC_WRAP_STOP_EN
    chk("long_busy", busy_cnt, 17);
    chk("long_done_idx", done_idx, 16);
`else
    chk("long_busy", busy_cnt, 256);
    chk("long_done_idx", done_idx, 255);
`endif

    // reset on the 4th RUN edge
    preload(4'h0);
    cmd_op = 3'd3; cmd_data = '0; cmd_len = 8'd10; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_q3", q, 4'h3);
    rst = 1'b0;
    #1 chk("mid_busy_rst", busy, 0);
    @(negedge clk);
    chk("mid_jk", {j_out, k_out}, 0);
    chk("mid_done", done, 0);
    chk("mid_q", q, 4'h4);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_ready", cmd_ready, 1);
    chk("mid_done2", done, 0);
    chk("mid_q_hold", q, 4'h4);
    do_cmd(3'd2, 4'b0011, 8'd1, 4, 0);
    chk("post_q", q, 4'b0011);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
